// File: rtl/quad_decoder_pkg.sv
// Shared types, constants and the quadrature transition decoder for quad_decoder.
package quad_decoder_pkg;

  localparam int WARMUP_EDGES = 4;
  localparam int ERR_CNT_W    = 4;

  // Phase pair packed as {A, B}
  typedef logic [1:0] phase_t;

  // Returns {step, dir, err} for a prev -> cur phase transition.
  // Forward (dir=1): 00->10->11->01->00. A single-bit change that is not
  // the forward successor must be the reverse one.
  function automatic logic [2:0] qd_decode(input phase_t prev, input phase_t cur);
    logic [2:0] res;
    res = 3'b000;
    if ((prev ^ cur) == 2'b11) begin
      res = 3'b001;
    end else if (prev != cur) begin
      case (prev)
        2'b00:   res = (cur == 2'b10) ? 3'b110 : 3'b100;
        2'b10:   res = (cur == 2'b11) ? 3'b110 : 3'b100;
        2'b11:   res = (cur == 2'b01) ? 3'b110 : 3'b100;
        default: res = (cur == 2'b00) ? 3'b110 : 3'b100;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_decoder_chan.sv
// One encoder phase: 2-flop synchroniser followed by an optional glitch filter.
// The filter is built only when QUAD_DECODER_FILTER_EN is defined; otherwise the
// synchronised phase is passed straight through.
module quad_decoder_chan
`ifdef QUAD_DECODER_FILTER_EN
  #(parameter int FILTER_LEN = 4)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic ph_in,
`ifdef QUAD_DECODER_FILTER_EN
  input  logic warm,
`endif
  output logic ph_filt
);

  logic sync1;
  logic sync2;

  // Bring the asynchronous phase into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ph_in;
      sync2 <= sync1;
    end
  end

`ifdef QUAD_DECODER_FILTER_EN
  localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);

  logic       filt;
  logic [3:0] run;

  // Accept a new level only after FILTER_LEN consecutive differing edges;
  // during warm-up the synchronised level is taken as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b0;
      run  <= 4'd0;
    end else if (warm) begin
      filt <= sync2;
      run  <= 4'd0;
    end else if (sync2 != filt) begin
      if (run == RUN_LAST) begin
        filt <= sync2;
        run  <= 4'd0;
      end else begin
        run <= run + 4'd1;
      end
    end else begin
      run <= 4'd0;
    end
  end

  assign ph_filt = filt;
`else
  assign ph_filt = sync2;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns encoder phases A/B into a one-cycle step pulse and a
// direction level (1 = up) for the downstream up/down counter. Illegal two-bit
// jumps raise err and are counted in a saturating err_cnt.
// Optional glitch filter per phase: define QUAD_DECODER_FILTER_EN.
module quad_decoder
  import quad_decoder_pkg::*;
  #(parameter int FILTER_LEN = 4)
  (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_decoder: FILTER_LEN must be in 1..15");
  end

  logic [2:0] wcnt;
  logic       warm;
  logic       a_filt;
  logic       b_filt;
  phase_t     cur;
  phase_t     prev;
  logic [2:0] dec;

  assign warm = (wcnt != 3'(WARMUP_EDGES));

`ifdef QUAD_DECODER_FILTER_EN
  quad_decoder_chan #(.FILTER_LEN(FILTER_LEN)) u_chan_a (
    .clk(clk), .reset(reset), .ph_in(a_in), .warm(warm), .ph_filt(a_filt));
  quad_decoder_chan #(.FILTER_LEN(FILTER_LEN)) u_chan_b (
    .clk(clk), .reset(reset), .ph_in(b_in), .warm(warm), .ph_filt(b_filt));
`else
  quad_decoder_chan u_chan_a (
    .clk(clk), .reset(reset), .ph_in(a_in), .ph_filt(a_filt));
  quad_decoder_chan u_chan_b (
    .clk(clk), .reset(reset), .ph_in(b_in), .ph_filt(b_filt));
`endif

  assign cur = {a_filt, b_filt};
  assign dec = qd_decode(prev, cur);

  // Warm-up absorbs the starting position silently; afterwards decode each
  // transition into registered step/dir/err and count illegal jumps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= 3'd0;
      prev    <= 2'b00;
      step    <= 1'b0;
      dir     <= 1'b1;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (warm) begin
      wcnt <= wcnt + 3'd1;
      prev <= cur;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      prev <= cur;
      step <= dec[2];
      err  <= dec[0];
      if (dec[2]) begin
        dir <= dec[1];
      end
      if (dec[0] && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (works with or without
// QUAD_DECODER_FILTER_EN; FILTER_LEN fixed at 4).
module tb_quad_decoder;

  logic       clk;
  logic       reset;
  logic       a_in;
  logic       b_in;
  logic       step;
  logic       dir;
  logic       err;
  logic [3:0] err_cnt;

`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = 20;

  int         vectors = 0;
  int         miss    = 0;
  logic [3:0] pos     = 4'd0;

  quad_decoder #(.FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .step(step), .dir(dir), .err(err), .err_cnt(err_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new AB at a negedge, hold HOLD cycles; expect exactly one
  // {step,dir,err} event LAT edges after capture and nothing elsewhere.
  task automatic apply(input logic [1:0] ab, input logic es, input logic ed,
                       input logic ee, input string tag);
    int   stray;
    logic [2:0] got;
    stray = 0;
    got   = 3'b000;
    a_in  = ab[1];
    b_in  = ab[0];
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      if (step) pos = dir ? pos + 4'd1 : pos - 4'd1;
      if (i == LAT) got = {step, dir, err};
      else if (step || err) stray++;
    end
    check(tag, 32'(got), 32'({es, ed, ee}));
    check({tag, "_stray"}, 32'(stray), 32'd0);
  endtask

  task automatic quiet_check(input int cycles, input string tag);
    int stray;
    stray = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (step || err) stray++;
    end
    check({tag, "_stray"}, 32'(stray), 32'd0);
  endtask

`ifdef QUAD_DECODER_FILTER_EN
  // Pulse A high for n cycles from AB=01 and collect the resulting steps.
  task automatic glitch(input int n, input int exp_steps, input logic [1:0] exp_dirs,
                        input string tag);
    int         steps;
    logic [1:0] dirs;
    steps = 0;
    dirs  = 2'b00;
    a_in  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == n - 1) a_in = 1'b0;
      if (step) begin
        steps++;
        dirs = {dirs[0], dir};
      end
    end
    check({tag, "_steps"}, 32'(steps), 32'(exp_steps));
    check({tag, "_dirs"}, 32'(dirs), 32'(exp_dirs));
  endtask
`endif

  initial begin
    reset = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b1;
    #12;
    check("reset_outputs", 32'({step, dir, err, err_cnt}), 32'({1'b0, 1'b1, 1'b0, 4'd0}));
    @(negedge clk);
    reset = 1'b0;
    quiet_check(12, "warmup");
    check("warmup_dir", 32'(dir), 32'd1);
    check("warmup_err_cnt", 32'(err_cnt), 32'd0);

    // Forward rotation from the power-up position 11
    apply(2'b01, 1'b1, 1'b1, 1'b0, "fwd_11_01");
    apply(2'b00, 1'b1, 1'b1, 1'b0, "fwd_01_00");
    apply(2'b10, 1'b1, 1'b1, 1'b0, "fwd_00_10");
    apply(2'b11, 1'b1, 1'b1, 1'b0, "fwd_10_11");
    apply(2'b01, 1'b1, 1'b1, 1'b0, "fwd_11_01b");
    apply(2'b00, 1'b1, 1'b1, 1'b0, "fwd_01_00b");

    // Reverse rotation; downstream counter from 0 wraps to 12
    pos = 4'd0;
    apply(2'b01, 1'b1, 1'b0, 1'b0, "rev_00_01");
    apply(2'b11, 1'b1, 1'b0, 1'b0, "rev_01_11");
    apply(2'b10, 1'b1, 1'b0, 1'b0, "rev_11_10");
    apply(2'b00, 1'b1, 1'b0, 1'b0, "rev_10_00");
    check("rev_counter", 32'(pos), 32'd12);

    // Illegal 00<->11 jumps: err each time, dir held at 0, count saturates
    for (int i = 1; i <= 17; i++) begin
      apply((i % 2 == 1) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b1, "illegal");
      check("err_cnt_sat", 32'(err_cnt), (i > 15) ? 32'd15 : 32'(i));
    end

    // Reset mid-rotation while dir=0 and err_cnt=15
    apply(2'b10, 1'b1, 1'b0, 1'b0, "rev_11_10_pre_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_outputs", 32'({step, dir, err, err_cnt}), 32'({1'b0, 1'b1, 1'b0, 4'd0}));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet_check(12, "rewarm");
    apply(2'b11, 1'b1, 1'b1, 1'b0, "post_reset_fwd");

`ifdef QUAD_DECODER_FILTER_EN
    apply(2'b01, 1'b1, 1'b1, 1'b0, "fwd_to_01");
    glitch(3, 0, 2'b00, "glitch_3");
    glitch(4, 2, 2'b01, "pulse_4");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
